// File: rtl/cpuori_oci_dct_pkg.sv
// Shared types and defaults for the cpuori OCI debug-capture-trace packer.
package cpuori_oci_dct_pkg;

  typedef enum logic [1:0] {
    ST_FILL  = 2'd0,
    ST_FULL  = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } dct_state_e;

  localparam int unsigned DEF_FRAME_W = 3;
  localparam int unsigned DEF_DEPTH   = 10;
  localparam int unsigned DEF_CNT_W   = 4;
  localparam int unsigned DEF_TS_W    = 16;

  // Bit offset of slot idx inside the packed buffer.
  function automatic int unsigned slot_off(input int unsigned idx, input int unsigned frame_w);
    return idx * frame_w;
  endfunction

endpackage

// File: rtl/cpuori_oci_dct_slot_wr.sv
// One-hot slot write-enable decoder driven by the packer write index.
module cpuori_oci_dct_slot_wr #(
  parameter int unsigned DEPTH = 10,
  parameter int unsigned CNT_W = 4
) (
  input  logic [CNT_W-1:0] i_idx,
  input  logic             i_en,
  output logic [DEPTH-1:0] o_slot_en
);

  always_comb begin
    o_slot_en = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (i_idx == CNT_W'(i)) o_slot_en[i] = i_en;
    end
  end

endmodule

// File: rtl/cpuori_oci_dct_packer.sv
// Packs narrow trace frames LSB-first into a wide buffer handed to the trace sink.
// Optional cycle timestamp of slot 0 enabled by CPUORI_OCI_DCT_TIMESTAMP_EN.
module cpuori_oci_dct_packer
  import cpuori_oci_dct_pkg::*;
#(
  parameter int unsigned FRAME_W = DEF_FRAME_W,
  parameter int unsigned DEPTH   = DEF_DEPTH,
  parameter int unsigned CNT_W   = DEF_CNT_W,
  parameter int unsigned TS_W    = DEF_TS_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [FRAME_W-1:0]       frame_data,
  input  logic                     frame_valid,
  output logic                     frame_ready,
  output logic [FRAME_W*DEPTH-1:0] dct_buffer,
  output logic [CNT_W-1:0]         dct_count,
  output logic                     dct_valid,
  input  logic                     dct_ready,
  output logic [TS_W-1:0]          dct_ts,
  input  logic                     test_ending,
  output logic                     test_has_ended
);

  localparam int unsigned BUF_W = FRAME_W * DEPTH;

  dct_state_e         r_state, w_state_nxt;
  logic [BUF_W-1:0]   r_buf, w_buf_nxt;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
  logic [CNT_W-1:0]   r_idx, w_idx_nxt;
  logic               r_valid, w_valid_nxt;
  logic               r_ended, w_ended_nxt;
  logic               r_end_pend, w_end_pend_nxt;

  logic               w_accept;
  logic [CNT_W-1:0]   w_wr_idx;
  logic [DEPTH-1:0]   w_slot_en;
  logic               w_last_slot;

  // In FULL the sink's ready is passed straight through so a frame can ride the handshake.
  assign frame_ready = (r_state == ST_FILL) | ((r_state == ST_FULL) & dct_ready);
  assign w_accept    = frame_valid & frame_ready;
  assign w_wr_idx    = (r_state == ST_FULL) ? '0 : r_idx;
  assign w_last_slot = (r_idx == CNT_W'(DEPTH - 1));

  cpuori_oci_dct_slot_wr #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_slot_wr (
    .i_idx     (w_wr_idx),
    .i_en      (w_accept),
    .o_slot_en (w_slot_en)
  );

  always_comb begin
    w_state_nxt    = r_state;
    w_buf_nxt      = r_buf;
    w_cnt_nxt      = r_cnt;
    w_idx_nxt      = r_idx;
    w_valid_nxt    = r_valid;
    w_ended_nxt    = r_ended;
    w_end_pend_nxt = r_end_pend;

    case (r_state)
      ST_FILL: begin
        if (w_accept) begin
          for (int unsigned i = 0; i < DEPTH; i++) begin
            if (w_slot_en[i]) w_buf_nxt[slot_off(i, FRAME_W) +: FRAME_W] = frame_data;
          end
          w_cnt_nxt = r_cnt + CNT_W'(1);
          if (w_last_slot) begin
            w_state_nxt    = ST_FULL;
            w_valid_nxt    = 1'b1;
            w_idx_nxt      = '0;
            w_end_pend_nxt = test_ending;
          end else begin
            w_idx_nxt = r_idx + CNT_W'(1);
            if (test_ending) begin
              w_state_nxt = ST_FLUSH;
              w_valid_nxt = 1'b1;
            end
          end
        end else if (test_ending) begin
          if (r_cnt == '0) begin
            w_state_nxt = ST_DONE;
            w_ended_nxt = 1'b1;
          end else begin
            w_state_nxt = ST_FLUSH;
            w_valid_nxt = 1'b1;
          end
        end
      end

      ST_FULL: begin
        if (test_ending) w_end_pend_nxt = 1'b1;
        if (dct_ready) begin
          w_buf_nxt   = '0;
          w_cnt_nxt   = '0;
          w_idx_nxt   = '0;
          w_valid_nxt = 1'b0;
          w_state_nxt = ST_FILL;
          if (w_accept) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
              if (w_slot_en[i]) w_buf_nxt[slot_off(i, FRAME_W) +: FRAME_W] = frame_data;
            end
            w_cnt_nxt = CNT_W'(1);
            w_idx_nxt = CNT_W'(1);
            // A frame riding the final handshake still has to be flushed before completion.
            if (r_end_pend | test_ending) begin
              w_state_nxt    = ST_FLUSH;
              w_valid_nxt    = 1'b1;
              w_end_pend_nxt = 1'b0;
            end
          end else if (r_end_pend | test_ending) begin
            w_state_nxt    = ST_DONE;
            w_ended_nxt    = 1'b1;
            w_end_pend_nxt = 1'b0;
          end
        end
      end

      ST_FLUSH: begin
        if (dct_ready) begin
          w_buf_nxt   = '0;
          w_cnt_nxt   = '0;
          w_idx_nxt   = '0;
          w_valid_nxt = 1'b0;
          w_state_nxt = ST_DONE;
          w_ended_nxt = 1'b1;
        end
      end

      default: begin
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_FILL;
      r_buf      <= '0;
      r_cnt      <= '0;
      r_idx      <= '0;
      r_valid    <= 1'b0;
      r_ended    <= 1'b0;
      r_end_pend <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_buf      <= w_buf_nxt;
      r_cnt      <= w_cnt_nxt;
      r_idx      <= w_idx_nxt;
      r_valid    <= w_valid_nxt;
      r_ended    <= w_ended_nxt;
      r_end_pend <= w_end_pend_nxt;
    end
  end

`ifdef CPUORI_OCI_DCT_TIMESTAMP_EN
  logic [TS_W-1:0] r_ts_cnt;
  logic [TS_W-1:0] r_ts;
  logic            w_ts_latch;

  assign w_ts_latch = w_accept & (w_wr_idx == '0);

  // Free-running cycle counter; its value when slot 0 is written travels with the buffer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ts_cnt <= '0;
      r_ts     <= '0;
    end else begin
      r_ts_cnt <= r_ts_cnt + TS_W'(1);
      if (w_ts_latch) r_ts <= r_ts_cnt;
    end
  end

  assign dct_ts = r_ts;
`else
  assign dct_ts = '0;
`endif

  assign dct_buffer     = r_buf;
  assign dct_count      = r_cnt;
  assign dct_valid      = r_valid;
  assign test_has_ended = r_ended;

endmodule

// File: tb/tb_cpuori_oci_dct_packer.sv
// Directed self-checking bench for cpuori_oci_dct_packer at default parameters.
module tb_cpuori_oci_dct_packer;

  localparam int unsigned FRAME_W = 3;
  localparam int unsigned DEPTH   = 10;
  localparam int unsigned CNT_W   = 4;
  localparam int unsigned TS_W    = 16;
  localparam int unsigned BUF_W   = FRAME_W * DEPTH;

  logic               clk = 1'b0;
  logic               reset;
  logic [FRAME_W-1:0] frame_data;
  logic               frame_valid;
  logic               frame_ready;
  logic [BUF_W-1:0]   dct_buffer;
  logic [CNT_W-1:0]   dct_count;
  logic               dct_valid;
  logic               dct_ready;
  logic [TS_W-1:0]    dct_ts;
  logic               test_ending;
  logic               test_has_ended;

  int n_tests = 0;
  int n_fail  = 0;

  logic [BUF_W-1:0] exp_buf;
  logic [TS_W-1:0]  exp_ts;

  cpuori_oci_dct_packer #(
    .FRAME_W (FRAME_W),
    .DEPTH   (DEPTH),
    .CNT_W   (CNT_W),
    .TS_W    (TS_W)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .frame_data     (frame_data),
    .frame_valid    (frame_valid),
    .frame_ready    (frame_ready),
    .dct_buffer     (dct_buffer),
    .dct_count      (dct_count),
    .dct_valid      (dct_valid),
    .dct_ready      (dct_ready),
    .dct_ts         (dct_ts),
    .test_ending    (test_ending),
    .test_has_ended (test_has_ended)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge; inputs change and outputs are sampled here.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset       = 1'b1;
    frame_valid = 1'b0;
    frame_data  = '0;
    dct_ready   = 1'b0;
    test_ending = 1'b0;
    step();
    step();
    reset = 1'b0;
  endtask

  // Offer DEPTH frames of the (i+1) mod 8 pattern, one per cycle, FILL accepting each.
  task automatic fill_pattern();
    exp_buf = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      frame_valid = 1'b1;
      frame_data  = FRAME_W'((i + 1) % 8);
      exp_buf[i*FRAME_W +: FRAME_W] = FRAME_W'((i + 1) % 8);
      step();
      if (i == int'(DEPTH) - 2) begin
        check("fill_cnt9", 64'(dct_count), 64'd9);
        check("fill_nvalid9", 64'(dct_valid), 64'd0);
      end
    end
    frame_valid = 1'b0;
  endtask

  initial begin
    do_reset();
    reset = 1'b1;
    #1;
    check("rst_buf", 64'(dct_buffer), 64'd0);
    check("rst_cnt", 64'(dct_count), 64'd0);
    check("rst_valid", 64'(dct_valid), 64'd0);
    check("rst_ts", 64'(dct_ts), 64'd0);
    check("rst_ended", 64'(test_has_ended), 64'd0);
    step();
    reset = 1'b0;

    // Full buffer with sink ready.
    dct_ready = 1'b1;
    fill_pattern();
    check("fill_valid", 64'(dct_valid), 64'd1);
    check("fill_cnt", 64'(dct_count), 64'd10);
    check("fill_buf", 64'(dct_buffer), 64'(exp_buf));
    check("fill_slot9", 64'(dct_buffer[29:27]), 64'd2);
    step();
    check("drain_valid", 64'(dct_valid), 64'd0);
    check("drain_cnt", 64'(dct_count), 64'd0);
    check("drain_buf", 64'(dct_buffer), 64'd0);

    // Backpressure, then a frame riding the handshake.
    do_reset();
    fill_pattern();
    frame_valid = 1'b1;
    frame_data  = 3'b111;
    for (int c = 0; c < 5; c++) begin
      #1;
      check("bp_fready", 64'(frame_ready), 64'd0);
      check("bp_buf", 64'(dct_buffer), 64'(exp_buf));
      check("bp_valid", 64'(dct_valid), 64'd1);
      step();
    end
    dct_ready = 1'b1;
    #1;
    check("bp_pass_ready", 64'(frame_ready), 64'd1);
    step();
    frame_valid = 1'b0;
    dct_ready   = 1'b0;
    check("bp_next_valid", 64'(dct_valid), 64'd0);
    check("bp_next_cnt", 64'(dct_count), 64'd1);
    check("bp_next_buf", 64'(dct_buffer), 64'd7);

    // Partial flush of four frames; test_ending rides the fourth.
    do_reset();
    exp_buf = '0;
    for (int i = 0; i < 4; i++) begin
      frame_valid = 1'b1;
      frame_data  = FRAME_W'(i + 3);
      exp_buf[i*FRAME_W +: FRAME_W] = FRAME_W'(i + 3);
      test_ending = (i == 3);
      step();
    end
    frame_valid = 1'b0;
    test_ending = 1'b0;
    check("pf_valid", 64'(dct_valid), 64'd1);
    check("pf_cnt", 64'(dct_count), 64'd4);
    check("pf_upper", 64'(dct_buffer[29:12]), 64'd0);
    check("pf_buf", 64'(dct_buffer), 64'(exp_buf));
    check("pf_fready", 64'(frame_ready), 64'd0);
    check("pf_nended", 64'(test_has_ended), 64'd0);
    dct_ready = 1'b1;
    step();
    check("pf_ended", 64'(test_has_ended), 64'd1);
    check("pf_valid_off", 64'(dct_valid), 64'd0);
    frame_valid = 1'b1;
    #1;
    check("pf_done_fready", 64'(frame_ready), 64'd0);
    step();
    frame_valid = 1'b0;
    check("pf_ended_hold", 64'(test_has_ended), 64'd1);
    check("pf_cnt_hold", 64'(dct_count), 64'd0);

    // Empty flush right after reset.
    do_reset();
    test_ending = 1'b1;
    step();
    test_ending = 1'b0;
    check("ef_ended", 64'(test_has_ended), 64'd1);
    check("ef_valid", 64'(dct_valid), 64'd0);
    step();
    check("ef_valid2", 64'(dct_valid), 64'd0);

    // Reset while a full buffer is stalled.
    do_reset();
    fill_pattern();
    check("rf_valid_pre", 64'(dct_valid), 64'd1);
    #2;
    reset = 1'b1;
    #1;
    check("rf_async_valid", 64'(dct_valid), 64'd0);
    check("rf_async_buf", 64'(dct_buffer), 64'd0);
    check("rf_async_cnt", 64'(dct_count), 64'd0);
    step();
    reset = 1'b0;
    #1;
    check("rf_fready", 64'(frame_ready), 64'd1);
    frame_valid = 1'b1;
    frame_data  = 3'b101;
    step();
    frame_valid = 1'b0;
    check("rf_refill_cnt", 64'(dct_count), 64'd1);
    check("rf_refill_buf", 64'(dct_buffer), 64'd5);

    // Slot 0 accepted when the cycle counter reads 5 after reset release.
    do_reset();
    for (int c = 0; c < 5; c++) step();
    frame_valid = 1'b1;
    frame_data  = 3'b011;
    step();
    frame_valid = 1'b1;
    frame_data  = 3'b110;
    step();
    frame_valid = 1'b0;
    test_ending = 1'b1;
    step();
    test_ending = 1'b0;
`ifdef CPUORI_OCI_DCT_TIMESTAMP_EN
    exp_ts = 16'h0005;
`else
    exp_ts = 16'h0000;
`endif
    check("ts_valid", 64'(dct_valid), 64'd1);
    check("ts_cnt", 64'(dct_count), 64'd2);
    check("ts_buf", 64'(dct_buffer), 64'h33);
    check("ts_val", 64'(dct_ts), 64'(exp_ts));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
